// File: rtl/triangle_feeder.sv
// Feeds packed side triples from a small FIFO to the serial triangle checker, one side per cycle,
// and returns each verdict with running counts. Define TRIANGLE_FEEDER_TIMEOUT_EN to abort stalled verdicts.
module triangle_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       S_VALID,
  output logic       S_READY,
  input  logic [8:0] S_DATA,
  output logic       M_VALID,
  output logic [2:0] M_DATA,
  input  logic       R_VALID,
  input  logic       R_OUT,
  output logic       RES_VALID,
  output logic       RES_TRI,
  output logic [7:0] TRI_COUNT,
  output logic [7:0] TOTAL_COUNT,
  output logic       ERR
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_param_check
    $error("triangle_feeder: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_SEND0, ST_SEND1, ST_SEND2, ST_WAIT} state_t;

  state_t      state;
  logic [8:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [8:0]  head;
  logic [5:0]  hold;   // sides b and c; side a leaves straight from the FIFO head
  logic        full, empty, push, pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign S_READY = !full;
  assign push    = S_VALID && !full;
  assign pop     = (state == ST_IDLE) && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array has no reset; emptiness is tracked by the pointers alone,
  // so clearing the data would only cost logic.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= S_DATA;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef TRIANGLE_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          err_q;
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      hold        <= '0;
      M_VALID     <= 1'b0;
      M_DATA      <= '0;
      RES_VALID   <= 1'b0;
      RES_TRI     <= 1'b0;
      TRI_COUNT   <= '0;
      TOTAL_COUNT <= '0;
`ifdef TRIANGLE_FEEDER_TIMEOUT_EN
      wait_cnt    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      RES_VALID <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            hold    <= head[5:0];
            M_VALID <= 1'b1;
            M_DATA  <= head[8:6];
            state   <= ST_SEND0;
          end
        end
        ST_SEND0: begin
          M_DATA <= hold[5:3];
          state  <= ST_SEND1;
        end
        ST_SEND1: begin
          M_DATA <= hold[2:0];
          state  <= ST_SEND2;
        end
        ST_SEND2: begin
          M_VALID <= 1'b0;
          M_DATA  <= '0;
          state   <= ST_WAIT;
`ifdef TRIANGLE_FEEDER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (R_VALID) begin
            RES_VALID   <= 1'b1;
            RES_TRI     <= R_OUT;
            TOTAL_COUNT <= sat_inc(TOTAL_COUNT);
            if (R_OUT) TRI_COUNT <= sat_inc(TRI_COUNT);
            state       <= ST_IDLE;
          end
`ifdef TRIANGLE_FEEDER_TIMEOUT_EN
          // expiry fires on the edge that ends the TIMEOUT-th silent WAIT cycle
          else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            RES_VALID <= 1'b1;
            RES_TRI   <= 1'b0;
            err_q     <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_feeder.sv
// Directed bench for triangle_feeder: latency, ordering, backpressure, reset, timeout and saturation.
module tb_triangle_feeder;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       S_VALID = 1'b0;
  logic       S_READY;
  logic [8:0] S_DATA = '0;
  logic       M_VALID;
  logic [2:0] M_DATA;
  logic       R_VALID = 1'b0;
  logic       R_OUT = 1'b0;
  logic       RES_VALID;
  logic       RES_TRI;
  logic [7:0] TRI_COUNT;
  logic [7:0] TOTAL_COUNT;
  logic       ERR;

  int vectors = 0;
  int errors  = 0;
  int exp_tri = 0;
  int exp_tot = 0;

  triangle_feeder #(.DEPTH(DEPTH), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
    .M_VALID(M_VALID), .M_DATA(M_DATA),
    .R_VALID(R_VALID), .R_OUT(R_OUT),
    .RES_VALID(RES_VALID), .RES_TRI(RES_TRI),
    .TRI_COUNT(TRI_COUNT), .TOTAL_COUNT(TOTAL_COUNT),
    .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [8:0] d);
    S_VALID = 1'b1;
    S_DATA  = d;
    tick();
    S_VALID = 1'b0;
  endtask

  // Waits (bounded) for SEND0, checks the three sides, ends in the first WAIT cycle.
  task automatic expect_sides(input logic [8:0] d);
    int n = 0;
    while (!M_VALID && n < 20) begin
      tick();
      n++;
    end
    check("send_start", M_VALID, 1);
    check("side_a", M_DATA, d[8:6]);
    tick();
    check("side_b_valid", M_VALID, 1);
    check("side_b", M_DATA, d[5:3]);
    tick();
    check("side_c_valid", M_VALID, 1);
    check("side_c", M_DATA, d[2:0]);
    tick();
    check("wait_mvalid", M_VALID, 0);
  endtask

  task automatic give_verdict(input logic v);
    R_VALID = 1'b1;
    R_OUT   = v;
    tick();
    R_VALID = 1'b0;
    R_OUT   = 1'b0;
    if (v && exp_tri < 255) exp_tri++;
    if (exp_tot < 255) exp_tot++;
    check("res_valid", RES_VALID, 1);
    check("res_tri", RES_TRI, v);
    check("tri_count", TRI_COUNT, exp_tri);
    check("total_count", TOTAL_COUNT, exp_tot);
  endtask

  logic [8:0] fill_data [5] = '{9'o123, 9'o234, 9'o345, 9'o456, 9'o567};

  initial begin
    int  n;
    logic was_ready;

    // Reset values
    RST = 1'b1;
    S_VALID = 1'b1; S_DATA = 9'o777;   // must be discarded
    tick(); tick();
    S_VALID = 1'b0;
    RST = 1'b0;
    check("rst_mvalid", M_VALID, 0);
    check("rst_mdata", M_DATA, 0);
    check("rst_res_valid", RES_VALID, 0);
    check("rst_res_tri", RES_TRI, 0);
    check("rst_tri", TRI_COUNT, 0);
    check("rst_total", TOTAL_COUNT, 0);
    check("rst_err", ERR, 0);
    check("rst_ready", S_READY, 1);
    tick();
    check("rst_push_dropped", M_VALID, 0);

    // (3,4,5): exact latency, push at edge e, verdict visible after e+5
    S_VALID = 1'b1; S_DATA = 9'o345;
    tick();
    S_VALID = 1'b0;
    check("lat_e_mvalid", M_VALID, 0);
    tick();
    check("lat_e1_mvalid", M_VALID, 1);
    check("lat_e1_a", M_DATA, 3);
    tick();
    check("lat_e2_b", M_DATA, 4);
    tick();
    check("lat_e3_c", M_DATA, 5);
    R_VALID = 1'b1; R_OUT = 1'b1;       // early answer during SEND2 is ignored
    tick();
    check("lat_e4_mvalid", M_VALID, 0);
    check("lat_e4_res_valid", RES_VALID, 0);
    tick();
    R_VALID = 1'b0; R_OUT = 1'b0;
    exp_tri = 1; exp_tot = 1;
    check("lat_e5_res_valid", RES_VALID, 1);
    check("lat_e5_res_tri", RES_TRI, 1);
    check("lat_e5_tri", TRI_COUNT, 1);
    check("lat_e5_total", TOTAL_COUNT, 1);
    tick();
    check("lat_e6_pulse_end", RES_VALID, 0);

    // R_VALID while IDLE is ignored
    R_VALID = 1'b1; R_OUT = 1'b1;
    tick(); tick();
    R_VALID = 1'b0; R_OUT = 1'b0;
    check("idle_rvalid_pulse", RES_VALID, 0);
    check("idle_rvalid_total", TOTAL_COUNT, 1);

    // (1,2,3), answered on the second WAIT cycle, not a triangle
    push(9'o123);
    expect_sides(9'o123);
    tick();
    check("t2_still_waiting", RES_VALID, 0);
    give_verdict(1'b0);

    // Backpressure: checker silent, S_VALID held high
    n = 0;
    S_VALID = 1'b1;
    for (int k = 0; k < 12; k++) begin
      S_DATA    = fill_data[(n < 5) ? n : 4];
      was_ready = S_READY;
      tick();
      if (was_ready) n++;
    end
    S_VALID = 1'b0;
    check("fill_accepted", n, DEPTH + 1);
    check("fill_ready_low", S_READY, 0);
    give_verdict(1'b0);
    check("fill_ready_before_pop", S_READY, 0);
    tick();
    check("fill_ready_after_pop", S_READY, 1);
    for (int i = 1; i < 5; i++) begin
      expect_sides(fill_data[i]);
      give_verdict(i[0]);
    end

    // Reset during SEND1
    push(9'o345);
    tick();
    tick();
    check("rst_mid_send1", M_DATA, 4);
    RST = 1'b1;
    S_VALID = 1'b1; S_DATA = 9'o777;
    tick();
    RST = 1'b0;
    S_VALID = 1'b0;
    exp_tri = 0; exp_tot = 0;
    check("rst_mid_mvalid", M_VALID, 0);
    check("rst_mid_tri", TRI_COUNT, 0);
    check("rst_mid_total", TOTAL_COUNT, 0);
    check("rst_mid_ready", S_READY, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_mid_fifo_empty", M_VALID, 0);
    end
    push(9'o234);
    expect_sides(9'o234);
    give_verdict(1'b1);

    // Silent checker: abort with the macro, indefinite wait without it
    push(9'o222);
    expect_sides(9'o222);
`ifdef TRIANGLE_FEEDER_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      tick();
      check("to_pending", RES_VALID, 0);
    end
    tick();
    check("to_res_valid", RES_VALID, 1);
    check("to_res_tri", RES_TRI, 0);
    check("to_err", ERR, 1);
    check("to_tri", TRI_COUNT, exp_tri);
    check("to_total", TOTAL_COUNT, exp_tot);
    tick();
    check("to_pulse_end", RES_VALID, 0);
`else
    for (int k = 0; k < 20; k++) begin
      tick();
      check("nto_waiting", RES_VALID, 0);
    end
    check("nto_err", ERR, 0);
    give_verdict(1'b0);
`endif
    push(9'o456);
    expect_sides(9'o456);
    give_verdict(1'b1);
`ifdef TRIANGLE_FEEDER_TIMEOUT_EN
    check("to_err_sticky", ERR, 1);
`else
    check("nto_err_zero", ERR, 0);
`endif

    // Saturation: 300 triangles, then one non-triangle
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp_tri = 0; exp_tot = 0;
    check("sat_rst_err", ERR, 0);
    for (int i = 0; i < 300; i++) begin
      push(9'o345);
      expect_sides(9'o345);
      give_verdict(1'b1);
    end
    check("sat_tri", TRI_COUNT, 255);
    check("sat_total", TOTAL_COUNT, 255);
    push(9'o123);
    expect_sides(9'o123);
    give_verdict(1'b0);
    check("sat_hold_tri", TRI_COUNT, 255);
    check("sat_hold_total", TOTAL_COUNT, 255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
